// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM state enum and default operand width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_is_signed(
    input logic [1:0] o
  );
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negator.
// Used for operand magnitudes and signed result fixups.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int W = MDU_WIDTH
) (
  input  logic         neg,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit producing Hi/Lo.
// Divider datapath present only when MDU_DIV_EN is defined.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_result,
  output logic [WIDTH-1:0] lo_result,
  output logic             hi_enable,
  output logic             lo_enable,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sgn_a_q, sgn_a_d;
  logic sgn_b_q, sgn_b_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [W2-1:0] acc_q, acc_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic hi_en_q, hi_en_d;
  logic lo_en_q, lo_en_d;
  logic dbz_q, dbz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic sgn_op;
  logic [WIDTH-1:0] abs_rs, abs_rt;
  logic [WIDTH:0] add_sum;
  logic [W2-1:0] prod_fix;

  assign sgn_op = op_is_signed(op);

  mdu_sign_fix #(.W(WIDTH)) u_abs_rs (
    .neg (sgn_op & rs_value[WIDTH-1]),
    .a   (rs_value),
    .y   (abs_rs)
  );

  mdu_sign_fix #(.W(WIDTH)) u_abs_rt (
    .neg (sgn_op & rt_value[WIDTH-1]),
    .a   (rt_value),
    .y   (abs_rt)
  );

  // Upper half accumulates the multiplicand when the low bit is set.
  assign add_sum = {1'b0, acc_q[W2-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opb_q} : '0);

  mdu_sign_fix #(.W(W2)) u_fix_prod (
    .neg (sgn_a_q ^ sgn_b_q),
    .a   (acc_q),
    .y   (prod_fix)
  );

`ifdef MDU_DIV_EN
  logic is_div_q, is_div_d;
  logic [WIDTH:0] rem_q, rem_d;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] rem_diff;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Quotient bits shift into the low half of acc as dividend bits leave.
  assign rem_sh   = {rem_q, acc_q[WIDTH-1]};
  assign rem_diff = rem_sh - {2'b0, opb_q};

  mdu_sign_fix #(.W(WIDTH)) u_fix_quo (
    .neg (sgn_a_q ^ sgn_b_q),
    .a   (acc_q[WIDTH-1:0]),
    .y   (quo_fix)
  );

  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
    .neg (sgn_a_q),
    .a   (rem_q[WIDTH-1:0]),
    .y   (rem_fix)
  );
`endif

  // Next-state and datapath updates for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_a_d = sgn_a_q;
    sgn_b_d = sgn_b_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_en_d = 1'b0;
    lo_en_d = 1'b0;
    dbz_d   = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
    rem_d    = rem_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sgn_a_d = sgn_op & rs_value[WIDTH-1];
          sgn_b_d = sgn_op & rt_value[WIDTH-1];
          cnt_d   = '0;
          busy_d  = 1'b1;
          if (op[1]) begin
`ifdef MDU_DIV_EN
            is_div_d = 1'b1;
            if (rt_value == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              dbz_d   = 1'b1;
            end else begin
              opb_d   = abs_rt;
              acc_d   = {{WIDTH{1'b0}}, abs_rs};
              rem_d   = '0;
              state_d = ST_CALC;
            end
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end else begin
`ifdef MDU_DIV_EN
            is_div_d = 1'b0;
`endif
            opb_d   = abs_rs;
            acc_d   = {{WIDTH{1'b0}}, abs_rt};
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          acc_d = {acc_q[W2-1:WIDTH],
                   acc_q[WIDTH-2:0],
                   ~rem_diff[WIDTH+1]};
          rem_d = rem_diff[WIDTH+1] ? rem_sh[WIDTH:0]
                                    : rem_diff[WIDTH:0];
        end
`endif
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        hi_en_d = 1'b1;
        lo_en_d = 1'b1;
        hi_d    = prod_fix[W2-1:WIDTH];
        lo_d    = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sgn_a_q <= 1'b0;
      sgn_b_q <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_en_q <= 1'b0;
      lo_en_q <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      rem_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_a_q <= sgn_a_d;
      sgn_b_q <= sgn_b_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_en_q <= hi_en_d;
      lo_en_q <= lo_en_d;
      dbz_q   <= dbz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
      rem_q    <= rem_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi_enable   = hi_en_q;
  assign lo_enable   = lo_en_q;
  assign div_by_zero = dbz_q;
  assign hi_result   = hi_q;
  assign lo_result   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (table, random, corner cases).
// Divide expectations follow whether MDU_DIV_EN is defined.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset, start;
  logic [1:0] op;
  logic [W-1:0] rs_value, rt_value;
  logic busy, done, hi_enable, lo_enable, div_by_zero;
  logic [W-1:0] hi_result, lo_result;

  int n_tests = 0;
  int n_fail  = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs_value    (rs_value),
    .rt_value    (rt_value),
    .busy        (busy),
    .done        (done),
    .hi_result   (hi_result),
    .lo_result   (lo_result),
    .hi_enable   (hi_enable),
    .lo_enable   (lo_enable),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        en;
    logic        dbz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        en;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  logic [31:0] ref_hi = '0;
  logic [31:0] ref_lo = '0;
  vec_t tbl[14];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Disabled-write results leave the previous Hi/Lo in place.
  function automatic exp_t finish_exp(input exp_t e);
    exp_t r = e;
    if (!r.en) begin
      r.hi = ref_hi;
      r.lo = ref_lo;
    end else begin
      ref_hi = r.hi;
      ref_lo = r.lo;
    end
    return r;
  endfunction

  function automatic exp_t from_row(input vec_t v);
    exp_t e;
    e.hi = v.hi; e.lo = v.lo;
    e.en = v.en; e.dbz = v.dbz; e.lat = v.lat;
`ifndef MDU_DIV_EN
    if (v.op[1]) begin
      e.en = 1'b0; e.dbz = 1'b0; e.lat = 1;
    end
`endif
    return finish_exp(e);
  endfunction

  // Reference built on native 64-bit arithmetic.
  function automatic exp_t model(input logic [1:0] o,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    longint sa, sd, q, r;
    e.hi = '0; e.lo = '0;
    e.en = 1'b1; e.dbz = 1'b0; e.lat = 34;
    if (!o[1]) begin
      if (o[0]) p = {32'b0, a} * {32'b0, b};
      else p = 64'(longint'($signed(a)) * longint'($signed(b)));
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else begin
`ifdef MDU_DIV_EN
      if (b == '0) begin
        e.en = 1'b0; e.dbz = 1'b1; e.lat = 1;
      end else begin
        if (o[0]) begin
          sa = longint'({32'b0, a});
          sd = longint'({32'b0, b});
        end else begin
          sa = longint'($signed(a));
          sd = longint'($signed(b));
        end
        q = sa / sd;
        r = sa % sd;
        e.lo = q[31:0];
        e.hi = r[31:0];
      end
`else
      e.en = 1'b0; e.lat = 1;
`endif
    end
    return finish_exp(e);
  endfunction

  task automatic issue(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    op = o; rs_value = a; rt_value = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for done, pops the scoreboard and compares everything.
  task automatic wait_done(input string name, input bit noise);
    exp_t e;
    int cyc = 1;
    check({name, " busy"}, 64'(busy), 64'(1));
    while (!done && cyc < 40) begin
      if (noise && cyc >= 4 && cyc < 10) begin
        start = 1'b1; op = MDU_DIV;
        rs_value = 32'd100; rt_value = 32'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      check({name, " sb empty"}, 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      check({name, " timeout"}, 64'(done), 64'(1));
      check({name, " lat"}, 64'(cyc), 64'(e.lat));
      check({name, " hi"}, 64'(hi_result), 64'(e.hi));
      check({name, " lo"}, 64'(lo_result), 64'(e.lo));
      check({name, " en"}, {62'b0, hi_enable, lo_enable},
            {62'b0, e.en, e.en});
      check({name, " dbz"}, 64'(div_by_zero), 64'(e.dbz));
      check({name, " busy@done"}, 64'(busy), 64'(1));
    end
    tick();
    check({name, " after"}, {62'b0, busy, done}, 64'(0));
  endtask

  initial begin
    int extra;
    logic [1:0] o;
    logic [31:0] a, b;

    tbl[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0, 34};
    tbl[1]  = '{MDU_MULT, 32'hFFFFFFFD, 32'h7,
                32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1, 1'b0, 34};
    tbl[2]  = '{MDU_DIV, 32'hFFFFFFF9, 32'h2,
                32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0, 34};
    tbl[3]  = '{MDU_DIVU, 32'd100, 32'd7,
                32'd2, 32'd14, 1'b1, 1'b0, 34};
    tbl[4]  = '{MDU_DIVU, 32'd100, 32'd0,
                32'd0, 32'd0, 1'b0, 1'b1, 1};
    tbl[5]  = '{MDU_DIV, 32'h80000000, 32'hFFFFFFFF,
                32'h0, 32'h80000000, 1'b1, 1'b0, 34};
    tbl[6]  = '{MDU_MULT, 32'h80000000, 32'h80000000,
                32'h40000000, 32'h0, 1'b1, 1'b0, 34};
    tbl[7]  = '{MDU_MULT, 32'h0, 32'hFFFFFFFF,
                32'h0, 32'h0, 1'b1, 1'b0, 34};
    tbl[8]  = '{MDU_MULT, 32'h12345678, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'hEDCBA988, 1'b1, 1'b0, 34};
    tbl[9]  = '{MDU_DIV, 32'h7, 32'hFFFFFFFE,
                32'h1, 32'hFFFFFFFD, 1'b1, 1'b0, 34};
    tbl[10] = '{MDU_DIV, 32'hFFFFFFF9, 32'hFFFFFFFE,
                32'hFFFFFFFF, 32'h3, 1'b1, 1'b0, 34};
    tbl[11] = '{MDU_DIVU, 32'hFFFFFFFF, 32'h1,
                32'h0, 32'hFFFFFFFF, 1'b1, 1'b0, 34};
    tbl[12] = '{MDU_DIV, 32'h5, 32'h0,
                32'h0, 32'h0, 1'b0, 1'b1, 1};
    tbl[13] = '{MDU_MULTU, 32'h2, 32'h3,
                32'h0, 32'h6, 1'b1, 1'b0, 34};

    reset = 1'b1; start = 1'b0; op = '0;
    rs_value = '0; rt_value = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset outs",
          {busy, done, hi_enable, lo_enable, div_by_zero,
           27'b0, hi_result | lo_result}, 64'(0));

    foreach (tbl[i]) begin
      sb.push_back(from_row(tbl[i]));
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_done($sformatf("tbl%0d", i), 1'b0);
    end

    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 4 == 3) ? 32'($urandom_range(0, 9)) : $urandom;
      sb.push_back(model(o, a, b));
      issue(o, a, b);
      wait_done($sformatf("rnd%0d", i), 1'b0);
    end

    sb.push_back(model(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF));
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("ignore start", 1'b1);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) extra++;
      tick();
    end
    check("single done", 64'(extra), 64'(0));

    issue(MDU_MULT, 32'h1234, 32'h5678);
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort outs",
          {busy, done, hi_enable, lo_enable, div_by_zero,
           27'b0, hi_result | lo_result}, 64'(0));
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || hi_enable || lo_enable) extra++;
      tick();
    end
    check("abort no done", 64'(extra), 64'(0));
    ref_hi = '0;
    ref_lo = '0;
    sb.push_back(model(MDU_MULT, 32'd2, 32'd3));
    issue(MDU_MULT, 32'd2, 32'd3);
    wait_done("post reset", 1'b0);
    check("sb drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath; executes MULT, MULTU, DIV and DIVU on two 32-bit register operands. It produces the 64-bit Hi/Lo pair together with the write strobes that drive the Hi and Lo registers. It sits beside the ALU in EX, and the pipeline stalls on `busy`.

## Interface
- `WIDTH`, 32, operand width; the iteration count equals WIDTH
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `rs_value`  in  WIDTH  multiplicand / dividend
- `rt_value`  in  WIDTH  multiplier / divisor
- `busy`  out  1  high from the accepting edge until DONE exits
- `done`  out  1  one-cycle completion pulse
- `hi_result`  out  WIDTH  Hi value (product upper half / remainder)
- `lo_result`  out  WIDTH  Lo value (product lower half / quotient)
- `hi_enable`, `lo_enable`  out  1  write strobes to the Hi/Lo registers; pulse with `done`
- `div_by_zero`  out  1  pulses with `done` when a divide has `rt_value == 0`

## Operation
- States: IDLE, CALC, FIX, DONE. The state encoding is 2-bit.
- IDLE with `start`=1 at an edge:
  - Captures `op` and both operands.
  - For signed ops, latches the operand signs and the absolute values.
  - Clears the counter, sets `busy`, and goes to CALC.
- CALC runs one radix-2 step per cycle for WIDTH cycles. The counter runs 0..WIDTH-1, then the unit goes to FIX.
  - Multiply: shift-add into a 2·WIDTH accumulator. All arithmetic is unsigned on magnitudes.
  - Divide: restoring shift-subtract. The remainder register is WIDTH+1 bits wide to hold the borrow.
- FIX applies the signed corrections:
  - MULT: the product is negated if the operand signs differ.
  - DIV: the quotient is negated if the signs differ. The remainder takes the sign of the dividend, so the quotient truncates toward zero.
- DONE lasts exactly one cycle:
  - `done`, `hi_enable` and `lo_enable` are 1.
  - The unit returns to IDLE.
- Division by zero:
  - The accepting edge goes straight to DONE.
  - `div_by_zero`=1, and `hi_enable`/`lo_enable` stay 0, so Hi/Lo are not written.
  - `hi_result`/`lo_result` keep their previous values.
- Special case 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0. No flag is raised.
- `hi_result`/`lo_result` hold the last completed result until the next DONE.

## Timing
- Reset values: state IDLE; `busy`, `done`, `hi_enable`, `lo_enable`, `div_by_zero` = 0; `hi_result`, `lo_result` = 0; counter = 0.
- Latency: accepting edge k, then `done` is high in the cycle after edge k+WIDTH+1. That is WIDTH+2 cycles, so 34 at the default.
- Divide-by-zero latency: `done` is high in the cycle after edge k (1 cycle).
- `busy` is 1 from the cycle after edge k through the DONE cycle inclusive. It is 0 again in the cycle after DONE.
- Back-to-back operation: `start` is ignored while `busy`=1. A new op can be accepted at the edge that ends DONE only if `busy` is sampled as 0, so the minimum spacing is one IDLE cycle.
- Reset mid-operation: at the next edge the unit is in IDLE with reset outputs. No `done` or write strobe is issued for the aborted op.
- Outputs are registered, so there is no combinational path from the inputs to the outputs.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are supported as described above.
- `MDU_DIV_EN` undefined:
  - The divider datapath is removed.
  - DIV/DIVU are accepted and go straight to DONE after 1 cycle.
  - `done`=1; `hi_enable`, `lo_enable` and `div_by_zero` = 0; the results are unchanged.
  - Multiply behaviour is identical in both builds.

## Structure
- Package `mdu_pkg` holds:
  - the op encodings (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`)
  - the state enum
  - the default WIDTH constant
- Sub-module `mdu_sign_fix` is a conditional two's-complement negator, parameterised by width. It is instantiated for operand magnitudes in IDLE and for the result corrections in FIX.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; `done` and both enables pulse 34 cycles after accept.
- MULT 0xFFFFFFFD (-3) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9 (-7) ÷ 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100 ÷ 7 -> lo=14, hi=2.
- DIVU 100 ÷ 0 -> `done` and `div_by_zero` one cycle after accept; enables 0; hi/lo unchanged from the previous op.
- `start` pulsed with op DIV during cycles 5–10 of a MULTU -> ignored; only one `done` at cycle 34, with the MULTU result.
- Reset asserted at cycle 10 of a MULT -> `busy`=0 the next cycle, all outputs 0, no `done` ever issued; a following MULT 2×3 gives lo=6, hi=0.
